mem_resp: RTL and testbench
===========================

MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter ADDR_BITS, default 10, meaning byte-address width of internal storage (2^ADDR_BITS bytes).
REQ-002 Parameter WAIT_CYCLES, default 2, meaning extra wait cycles per access, range 0..255.
REQ-003 I_clk  in  1  single clock; all state changes on rising edge.
REQ-004 I_reset  in  1  reset, asynchronous, active-low.
REQ-005 I_exec  in  1  access request, accepted only while O_ready=1.
REQ-006 I_write  in  1  1=write, 0=read; sampled with I_exec.
REQ-007 I_size  in  2  00=byte, 01/10/11=16-bit word; sampled with I_exec.
REQ-008 I_addr  in  16  byte address; bits above ADDR_BITS-1 ignored (aliasing).
REQ-009 I_data  in  16  write data; byte writes use I_data[7:0].
REQ-010 O_ready  out  1  idle and able to accept a request.
REQ-011 O_data  out  16  read data, held until the next read completes.
REQ-012 O_data_ready  out  1  one-cycle pulse marking O_data valid for a completed read.
REQ-013 O_fault  out  1  one-cycle pulse marking a rejected access (see Configuration).

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 O_ready SHALL equal (state==IDLE) && !I_exec, combinationally, so it drops in the cycle I_exec is presented.
REQ-016 At an edge with state==IDLE and I_exec=1, I_write, I_size, I_addr, I_data SHALL be captured; the inputs need not be held afterwards.
REQ-017 From IDLE with accepted request: to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else to RESP.
REQ-018 WAIT: counter decrements each edge; at 0 goes to RESP.
REQ-019 RESP: access performed at the edge leaving RESP; next state IDLE; O_ready=0 throughout WAIT and RESP.
REQ-020 Read latency: O_data_ready SHALL be high exactly one cycle, WAIT_CYCLES+2 cycles after the I_exec cycle, with O_data valid in that cycle and after.
REQ-021 Writes SHALL NOT assert O_data_ready; completion is indicated only by O_ready returning high.
REQ-022 Byte order little-endian: word at A holds byte A in [7:0], byte A+1 in [15:8].
REQ-023 Byte read returns {8'h00, byte}; byte write modifies one byte only.
REQ-024 I_exec while state!=IDLE SHALL be ignored with no side effect.
REQ-025 Address arithmetic wraps modulo 2^ADDR_BITS; word at top address pairs with the lower byte partner after alignment (REQ-029/030), never out of range.

Reset
REQ-026 I_reset=0 SHALL immediately force state=IDLE, counter=0, O_data=16'h0000, O_data_ready=0, O_fault=0.
REQ-027 Reset during WAIT or RESP SHALL abort the access; a pending write SHALL NOT modify storage.
REQ-028 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With MEM_RESP_ALIGN_CHECK_EN defined: a word access with captured addr[0]=1 SHALL complete with normal timing, pulse O_fault in the RESP-exit cycle instead of/with O_data_ready, leave storage unchanged, and for reads set O_data=16'h0000 with O_data_ready pulsed.
REQ-030 Without MEM_RESP_ALIGN_CHECK_EN: addr[0] SHALL be forced to 0 for word accesses, and O_fault SHALL be tied 0.

Verification
REQ-031 Reset, then write word 16'hBEEF to 16'h0010, read 16'h0010 -> O_data_ready 4 cycles after read exec cycle, O_data=16'hBEEF.
REQ-032 Byte write 8'h5A to 16'h0011 after REQ-031, word read 16'h0010 -> 16'h5AEF; byte read 16'h0011 -> 16'h005A.
REQ-033 WAIT_CYCLES=0: read exec -> O_data_ready in 2nd cycle; O_ready low in exec and next cycle, high after.
REQ-034 I_exec pulsed while in WAIT -> no extra access, no O_data_ready beyond the first; I_reset low during WAIT of write 16'h1234 to 16'h0020 -> subsequent read returns prior content.
REQ-035 Address 16'h0410 with ADDR_BITS=10 aliases 16'h0010 -> reads 16'h5AEF.
REQ-036 Word read at 16'h0011: with MEM_RESP_ALIGN_CHECK_EN -> O_fault pulse, O_data=16'h0000; without -> O_data=16'h5AEF, O_fault=0.

Source files
------------

// File: rtl/mem_resp_if.sv
// mem_resp_if: request/response bus between a requester and the mem_resp
// byte-addressed storage responder.
interface mem_resp_if;
    logic        I_exec;
    logic        I_write;
    logic [1:0]  I_size;
    logic [15:0] I_addr;
    logic [15:0] I_data;
    logic        O_ready;
    logic [15:0] O_data;
    logic        O_data_ready;
    logic        O_fault;

    modport slave (
        input  I_exec, I_write, I_size, I_addr, I_data,
        output O_ready, O_data, O_data_ready, O_fault
    );

    modport master (
        output I_exec, I_write, I_size, I_addr, I_data,
        input  O_ready, O_data, O_data_ready, O_fault
    );
endinterface

// File: rtl/mem_resp.sv
// mem_resp: small byte-addressed storage with fixed access latency.
// Requests are captured in IDLE, wait WAIT_CYCLES cycles, and the access is
// performed on the edge leaving RESP. Little-endian 16-bit words.
// Optional feature: define MEM_RESP_ALIGN_CHECK_EN to reject misaligned word
// accesses with an O_fault pulse; otherwise word addresses are force-aligned.
//
// state | meaning
// IDLE  | waiting for I_exec, O_ready high when I_exec low
// WAIT  | counting down the extra wait cycles
// RESP  | access performed on the edge leaving this state
module mem_resp #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic       I_clk,
    input logic       I_reset,
    mem_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t state, state_nxt;
    logic [7:0] cnt, cnt_nxt;

    logic                 cap_write;
    logic                 cap_word;
    logic [ADDR_BITS-1:0] cap_addr;
    logic [15:0]          cap_data;

    logic [7:0] mem [2**ADDR_BITS];

    logic [ADDR_BITS-1:0] addr_lo;
    logic [ADDR_BITS-1:0] addr_hi;
    logic                 misalign;
    logic                 do_access;
    logic [15:0]          rd_word;
    logic [15:0]          data_q;
    logic                 data_ready_q;

    wire unused_addr_hi = ^bus.I_addr[15:ADDR_BITS];

    // State register and wait counter
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (bus.I_exec) begin
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = WAIT_LOAD;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 8'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 8'd1;
            end
            RESP: state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // Capture request fields on acceptance so inputs need not be held
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            cap_write <= 1'b0;
            cap_word  <= 1'b0;
            cap_addr  <= '0;
            cap_data  <= 16'h0000;
        end else if (state == IDLE && bus.I_exec) begin
            cap_write <= bus.I_write;
            cap_word  <= |bus.I_size;
            cap_addr  <= bus.I_addr[ADDR_BITS-1:0];
            cap_data  <= bus.I_data;
        end
    end

`ifdef MEM_RESP_ALIGN_CHECK_EN
    assign addr_lo  = cap_addr;
    assign misalign = cap_word & cap_addr[0];
`else
    assign addr_lo  = cap_word ? {cap_addr[ADDR_BITS-1:1], 1'b0} : cap_addr;
    assign misalign = 1'b0;
`endif

    // High byte partner wraps within the storage
    assign addr_hi   = addr_lo + ADDR_ONE;
    assign do_access = (state == RESP);
    assign rd_word   = cap_word ? {mem[addr_hi], mem[addr_lo]} : {8'h00, mem[addr_lo]};

    // Storage write; no reset so contents survive reset
    always_ff @(posedge I_clk) begin
        if (do_access && cap_write && !misalign) begin
            mem[addr_lo] <= cap_data[7:0];
            if (cap_word) mem[addr_hi] <= cap_data[15:8];
        end
    end

    // Read response register and completion pulse
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) begin
            data_q       <= 16'h0000;
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            if (do_access && !cap_write) begin
                data_ready_q <= 1'b1;
                data_q       <= misalign ? 16'h0000 : rd_word;
            end
        end
    end

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic fault_q;

    // Fault pulse for a rejected misaligned word access
    always_ff @(posedge I_clk or negedge I_reset) begin
        if (!I_reset) fault_q <= 1'b0;
        else          fault_q <= do_access && misalign;
    end

    assign bus.O_fault = fault_q;
`else
    assign bus.O_fault = 1'b0;
`endif

    assign bus.O_ready      = (state == IDLE) && !bus.I_exec;
    assign bus.O_data       = data_q;
    assign bus.O_data_ready = data_ready_q;
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed tests for mem_resp; dut0 uses WAIT_CYCLES=2,
// dut1 uses WAIT_CYCLES=0.
module tb_mem_resp;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_resp_if m0 ();
    mem_resp_if m1 ();

    mem_resp #(.ADDR_BITS(10), .WAIT_CYCLES(2)) dut0 (.I_clk(clk), .I_reset(rst_n), .bus(m0));
    mem_resp #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut1 (.I_clk(clk), .I_reset(rst_n), .bus(m1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input int which, input logic ex, input logic wr, input logic [1:0] sz,
                         input logic [15:0] ad, input logic [15:0] dt);
        if (which == 0) begin
            m0.I_exec = ex; m0.I_write = wr; m0.I_size = sz; m0.I_addr = ad; m0.I_data = dt;
        end else begin
            m1.I_exec = ex; m1.I_write = wr; m1.I_size = sz; m1.I_addr = ad; m1.I_data = dt;
        end
    endtask

    // One access; mode 1 injects a write request during the cycle after exec.
    // Cycle numbers count from the exec cycle (0).
    task automatic access(input int which, input int mode, input logic wr, input logic [1:0] sz,
                          input logic [15:0] ad, input logic [15:0] dt,
                          output int lat, output int pulses, output int faults,
                          output logic [15:0] rdat, output logic rdy_exec, output int rdy_cycle);
        logic s_ready, s_dr, s_fault;
        logic [15:0] s_data;
        lat = -1; pulses = 0; faults = 0; rdat = 16'hxxxx; rdy_cycle = -1;
        @(posedge clk); #1;
        drive(which, 1'b1, wr, sz, ad, dt);
        #1;
        rdy_exec = (which == 0) ? m0.O_ready : m1.O_ready;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (n == 1 && mode == 1) drive(which, 1'b1, 1'b1, 2'b01, 16'h0010, 16'hDEAD);
            else                     drive(which, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
            #1;
            s_ready = (which == 0) ? m0.O_ready      : m1.O_ready;
            s_dr    = (which == 0) ? m0.O_data_ready : m1.O_data_ready;
            s_fault = (which == 0) ? m0.O_fault      : m1.O_fault;
            s_data  = (which == 0) ? m0.O_data       : m1.O_data;
            if (s_dr) begin
                pulses++;
                if (lat < 0) begin lat = n; rdat = s_data; end
            end
            if (s_fault) faults++;
            if (rdy_cycle >= 0 && n > rdy_cycle + 1) break;
            if (s_ready && rdy_cycle < 0) rdy_cycle = n;
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        drive(1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (m0.O_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", m0.O_data); end
        checks++; if (m0.O_data_ready !== 1'b0) begin errors++; $display("FAIL reset_dr got %b want 0", m0.O_data_ready); end
        checks++; if (m0.O_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", m0.O_fault); end
        checks++; if (m0.O_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", m0.O_ready); end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_word_write_read();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(0, 0, 1'b1, 2'b01, 16'h0010, 16'hBEEF, lat, pulses, faults, rd, re, rc);
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL wr_ready_exec got %b want 0", re); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL wr_no_dr got %0d want 0", pulses); end
        checks++; if (rc !== 4) begin errors++; $display("FAIL wr_ready_return got %0d want 4", rc); end
        access(0, 0, 1'b0, 2'b01, 16'h0010, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rd_latency got %0d want 4", lat); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL rd_pulses got %0d want 1", pulses); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_beef got %h want beef", rd); end
        checks++; if (m0.O_data !== 16'hBEEF) begin errors++; $display("FAIL rd_hold got %h want beef", m0.O_data); end
    endtask

    task automatic test_byte_access();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(0, 0, 1'b1, 2'b00, 16'h0011, 16'hFF5A, lat, pulses, faults, rd, re, rc);
        access(0, 0, 1'b0, 2'b10, 16'h0010, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h5AEF) begin errors++; $display("FAIL byte_word_rd got %h want 5aef", rd); end
        access(0, 0, 1'b0, 2'b00, 16'h0011, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h005A) begin errors++; $display("FAIL byte_rd_hi got %h want 005a", rd); end
        access(0, 0, 1'b0, 2'b00, 16'h0010, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h00EF) begin errors++; $display("FAIL byte_rd_lo got %h want 00ef", rd); end
    endtask

    task automatic test_top_address();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(0, 0, 1'b1, 2'b00, 16'h03FE, 16'h0011, lat, pulses, faults, rd, re, rc);
        access(0, 0, 1'b1, 2'b00, 16'h03FF, 16'h0022, lat, pulses, faults, rd, re, rc);
        access(0, 0, 1'b0, 2'b01, 16'h03FE, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h2211) begin errors++; $display("FAIL top_word got %h want 2211", rd); end
        access(0, 0, 1'b0, 2'b01, 16'hFFFE, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h2211) begin errors++; $display("FAIL top_alias got %h want 2211", rd); end
    endtask

    task automatic test_exec_in_wait();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(0, 1, 1'b0, 2'b01, 16'h0010, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ign_pulses got %0d want 1", pulses); end
        checks++; if (rd !== 16'h5AEF) begin errors++; $display("FAIL ign_data got %h want 5aef", rd); end
        access(0, 0, 1'b0, 2'b01, 16'h0010, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h5AEF) begin errors++; $display("FAIL ign_no_write got %h want 5aef", rd); end
    endtask

    task automatic test_reset_abort();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(0, 0, 1'b1, 2'b01, 16'h0020, 16'hCAFE, lat, pulses, faults, rd, re, rc);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 2'b01, 16'h0020, 16'h1234);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        #1;
        checks++; if (m0.O_data !== 16'h0000) begin errors++; $display("FAIL abort_data got %h want 0000", m0.O_data); end
        checks++; if (m0.O_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", m0.O_ready); end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        access(0, 0, 1'b0, 2'b01, 16'h0020, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'hCAFE) begin errors++; $display("FAIL abort_keep got %h want cafe", rd); end
    endtask

    task automatic test_alias();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(0, 0, 1'b0, 2'b01, 16'h0410, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h5AEF) begin errors++; $display("FAIL alias got %h want 5aef", rd); end
    endtask

    task automatic test_misaligned();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(0, 0, 1'b0, 2'b01, 16'h0011, 16'h0000, lat, pulses, faults, rd, re, rc);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        checks++; if (faults !== 1) begin errors++; $display("FAIL mis_fault got %0d want 1", faults); end
        checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL mis_data got %h want 0000", rd); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL mis_latency got %0d want 4", lat); end
        access(0, 0, 1'b1, 2'b01, 16'h0011, 16'hFFFF, lat, pulses, faults, rd, re, rc);
        checks++; if (faults !== 1) begin errors++; $display("FAIL mis_wr_fault got %0d want 1", faults); end
        access(0, 0, 1'b0, 2'b01, 16'h0010, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (rd !== 16'h5AEF) begin errors++; $display("FAIL mis_wr_keep got %h want 5aef", rd); end
`else
        checks++; if (faults !== 0) begin errors++; $display("FAIL mis_fault got %0d want 0", faults); end
        checks++; if (rd !== 16'h5AEF) begin errors++; $display("FAIL mis_data got %h want 5aef", rd); end
`endif
    endtask

    task automatic test_zero_wait();
        int lat, pulses, faults, rc; logic [15:0] rd; logic re;
        access(1, 0, 1'b1, 2'b01, 16'h0100, 16'hA55A, lat, pulses, faults, rd, re, rc);
        checks++; if (rc !== 2) begin errors++; $display("FAIL zw_wr_ready got %0d want 2", rc); end
        access(1, 0, 1'b0, 2'b01, 16'h0100, 16'h0000, lat, pulses, faults, rd, re, rc);
        checks++; if (re !== 1'b0) begin errors++; $display("FAIL zw_ready_exec got %b want 0", re); end
        checks++; if (rc !== 2) begin errors++; $display("FAIL zw_ready_return got %0d want 2", rc); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL zw_latency got %0d want 2", lat); end
        checks++; if (rd !== 16'hA55A) begin errors++; $display("FAIL zw_data got %h want a55a", rd); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        test_reset();
        test_word_write_read();
        test_byte_access();
        test_top_address();
        test_exec_in_wait();
        test_reset_abort();
        test_alias();
        test_misaligned();
        test_zero_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
